// File: rtl/room_cmd_gen.sv
// Button-to-command generator for the room FSM: sync, debounce, combine, emit one-cycle strobes.
// Optional build macro ROOM_CMD_GEN_AUTOPLAY_EN adds the built-in winning autoplay sequence.

module room_cmd_gen #(
  parameter int unsigned DB_CYC      = 4,
  parameter int unsigned COMBINE_CYC = 3,
  parameter int unsigned AUTO_GAP    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  input  logic       autoplay,
  input  logic       sw,
  input  logic       win,
  input  logic       d,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       v,
  output logic [7:0] moves,
  output logic       rej,
  output logic       locked
);

  localparam int unsigned DbW  = $clog2(DB_CYC + 1);
  localparam int unsigned CmbW = $clog2(COMBINE_CYC + 1);

  typedef enum logic [2:0] {
    StIdle, StCombine, StEmit, StRelease, StAuto, StLocked
  } state_e;

  // Button vectors are ordered {n, s, e, w}.
  logic [3:0]          sync1_q, sync2_q, db_q;
  logic [3:0][DbW-1:0] db_cnt_q;

  state_e              state_q;
  logic [CmbW-1:0]     cmb_cnt_q;
  logic [3:0]          cmd_q;
  logic [7:0]          moves_q;
  logic                rej_q, locked_q, v_q;

  function automatic logic legal_f(input logic [3:0] c);
    case (c)
      4'b1000, 4'b0100, 4'b0010, 4'b0001,
      4'b1010, 4'b1001, 4'b0110, 4'b0101: legal_f = 1'b1;
      default:                            legal_f = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    sat_inc = (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= {btn_n, btn_s, btn_e, btn_w};
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DbW'(DB_CYC - 1)) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= 1'b0;
    end else if (sw) begin
      v_q <= 1'b1;
    end
  end

`ifdef ROOM_CMD_GEN_AUTOPLAY_EN
  localparam int unsigned GapW = $clog2(AUTO_GAP + 1);

  logic [GapW-1:0] gap_cnt_q;
  logic [2:0]      step_q;

  function automatic logic [3:0] auto_code(input logic [2:0] idx);
    case (idx)
      3'd0:    auto_code = 4'b0010;
      3'd1:    auto_code = 4'b0100;
      3'd2:    auto_code = 4'b0001;
      3'd3:    auto_code = 4'b0010;
      default: auto_code = 4'b0110;
    endcase
  endfunction
`else
  logic unused_autoplay;
  assign unused_autoplay = autoplay ^ (AUTO_GAP == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cmb_cnt_q <= '0;
      cmd_q     <= '0;
      moves_q   <= '0;
      rej_q     <= 1'b0;
      locked_q  <= 1'b0;
`ifdef ROOM_CMD_GEN_AUTOPLAY_EN
      gap_cnt_q <= '0;
      step_q    <= '0;
`endif
    end else begin
      cmd_q <= '0;
      rej_q <= 1'b0;
      // Game end wins over any pending emit in the same cycle.
      if (win || d) begin
        state_q  <= StLocked;
        locked_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
`ifdef ROOM_CMD_GEN_AUTOPLAY_EN
            if (autoplay) begin
              state_q   <= StAuto;
              gap_cnt_q <= GapW'(AUTO_GAP - 1);
              step_q    <= '0;
            end else
`endif
            if (|db_q) begin
              state_q   <= StCombine;
              cmb_cnt_q <= CmbW'(COMBINE_CYC);
            end
          end
          StCombine: begin
            if (cmb_cnt_q == '0) begin
              if (legal_f(db_q)) begin
                cmd_q   <= db_q;
                moves_q <= sat_inc(moves_q);
                state_q <= StEmit;
              end else begin
                rej_q   <= 1'b1;
                state_q <= StRelease;
              end
            end else begin
              cmb_cnt_q <= cmb_cnt_q - CmbW'(1);
            end
          end
          StEmit: state_q <= StRelease;
          StRelease: begin
            if (db_q == '0) state_q <= StIdle;
          end
`ifdef ROOM_CMD_GEN_AUTOPLAY_EN
          StAuto: begin
            if (gap_cnt_q == '0) begin
              cmd_q     <= auto_code(step_q);
              moves_q   <= sat_inc(moves_q);
              gap_cnt_q <= GapW'(AUTO_GAP - 1);
              step_q    <= step_q + 3'd1;
              if (step_q == 3'd4) state_q <= StRelease;
            end else begin
              gap_cnt_q <= gap_cnt_q - GapW'(1);
            end
          end
`endif
          StLocked: state_q <= StLocked;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  assign n      = cmd_q[3];
  assign s      = cmd_q[2];
  assign e      = cmd_q[1];
  assign w      = cmd_q[0];
  assign v      = v_q;
  assign moves  = moves_q;
  assign rej    = rej_q;
  assign locked = locked_q;

endmodule

// File: doc/room_cmd_gen.md
ROOM_CMD_GEN -- requirements
Module: room_cmd_gen

Interface
REQ-001 Parameter DB_CYC, default 4: consecutive synchronized samples needed to change a debounced button.
REQ-002 Parameter COMBINE_CYC, default 3: cycles to collect a multi-button command after the first press.
REQ-003 Parameter AUTO_GAP, default 8: cycles between autoplay commands.
REQ-004 clk  in  1  the only clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 btn_n, btn_s, btn_e, btn_w  in  1 each  raw asynchronous direction buttons, active-high.
REQ-007 autoplay  in  1  request for the built-in winning sequence.
REQ-008 sw, win, d  in  1 each  room-FSM status: sword room, win, dead.
REQ-009 n, s, e, w  out  1 each  registered command strobes to the room FSM.
REQ-010 v  out  1  registered sword-held flag to the room FSM.
REQ-011 moves  out  8  count of emitted commands.
REQ-012 rej  out  1  one-cycle pulse when an illegal button combination is discarded.
REQ-013 locked  out  1  high once the game has ended.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a per-button debouncer that flips its debounced value only after DB_CYC consecutive differing synchronized samples.
REQ-015 FSM states SHALL be IDLE, COMBINE, EMIT, RELEASE, AUTO, LOCKED.
REQ-016 IDLE: on a nonzero debounced vector -> COMBINE and load the combine counter with COMBINE_CYC.
REQ-017 COMBINE: decrement each cycle; at zero, sample the debounced vector -> EMIT if legal, else pulse rej and go to RELEASE.
REQ-018 Legal codes SHALL be: exactly one bit, or one of NE, NW, SE, SW; N+S, E+W, three or four bits, and all-zero are illegal.
REQ-019 EMIT: drive the sampled code on n/s/e/w for exactly one cycle, increment moves, then -> RELEASE.
REQ-020 RELEASE: stay until the debounced vector is all-zero, then -> IDLE; no command is emitted while any button is held.
REQ-021 With default parameters, a clean single press SHALL produce its strobe 10 cycles after the raw edge is first sampled.
REQ-022 moves SHALL saturate at 255.
REQ-023 v SHALL set the cycle after sw is sampled high and stay high until reset.
REQ-024 win or d sampled high in any state SHALL force LOCKED next cycle with n/s/e/w low; LOCKED is left only by reset.
REQ-025 If win or d is high in the same cycle as EMIT would occur, the lock SHALL take priority and no strobe is issued.
REQ-026 n/s/e/w SHALL never be high in two consecutive cycles.

Reset
REQ-027 While reset_n is low: state IDLE, n/s/e/w/v/rej/locked = 0, moves = 0, synchronizers and debounced values = 0, counters = 0.
REQ-028 Reset asserted mid-COMBINE, EMIT or AUTO SHALL abort without emitting a strobe.

Configuration
REQ-029 Macro ROOM_CMD_GEN_AUTOPLAY_EN defined: autoplay high in IDLE -> AUTO, which emits E, S, W, E, SE (one-cycle strobes, AUTO_GAP cycles apart, first strobe AUTO_GAP cycles after entry), ignores buttons, then -> RELEASE; moves counts each strobe.
REQ-030 Macro ROOM_CMD_GEN_AUTOPLAY_EN undefined: autoplay is ignored, AUTO is unreachable, and no AUTO logic is synthesized.

Verification
REQ-031 Press btn_e clean for 20 cycles -> single e strobe at cycle 10, moves=1, no further strobes until release.
REQ-032 btn_s then btn_e 1 cycle apart, both held -> single cycle with s=e=1, moves=1.
REQ-033 btn_n+btn_s together -> rej pulse once, no strobe, moves unchanged.
REQ-034 Bounce btn_w toggling every 2 cycles for 12 cycles -> no strobe.
REQ-035 sw high for 1 cycle then win high -> v=1 next cycle and stays; locked=1; later presses give no strobes; reset_n low clears all outputs.
REQ-036 With ROOM_CMD_GEN_AUTOPLAY_EN, autoplay=1 -> strobes E,S,W,E,SE at cycles 8,16,24,32,40 after AUTO entry; moves=5.
